// File: rtl/instr_encoder.sv
// Streaming RV64I instruction encoder: builds 32-bit instruction words from
// opcode/funct/register/immediate fields and buffers them in a small FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_op,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_err,
  input  logic                     err_clr,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic signed [31:0] imm_s;
  logic               imm_ok_12;
  logic               imm_ok_b;
  logic               imm_ok_j;
  logic               is_shift;
  logic               shift_bit30;
  logic [31:0]        enc_raw;
  logic               enc_err;
  logic [31:0]        enc_word;

  assign imm_s       = $signed(in_imm);
  assign imm_ok_12   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign imm_ok_b    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign imm_ok_j    = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
  assign is_shift    = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  // Arithmetic-shift select only exists for the right-shift encoding.
  assign shift_bit30 = (in_funct3 == 3'b101) && in_funct7[5];

  always_comb begin
    enc_raw = '0;
    enc_err = 1'b0;
    case (in_op)
      OPC_LUI, OPC_AUIPC: begin
        enc_raw = {in_imm[31:12], in_rd, in_op};
        enc_err = (in_imm[11:0] != 12'd0);
      end
      OPC_JAL: begin
        enc_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        enc_err = !imm_ok_j;
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
        enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        enc_err = !imm_ok_12;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          enc_raw = {1'b0, shift_bit30, 4'b0000, in_imm[5:0], in_rs1, in_funct3, in_rd, in_op};
          enc_err = (in_imm[11:6] != 6'd0);
        end else begin
          enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
          enc_err = !imm_ok_12;
        end
      end
      OPC_OP_IMM_32: begin
        if (is_shift) begin
          enc_raw = {1'b0, shift_bit30, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
          enc_err = (in_imm[11:5] != 7'd0);
        end else begin
          enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
          enc_err = !imm_ok_12;
        end
      end
      OPC_BRANCH: begin
        enc_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_op};
        enc_err = !imm_ok_b;
      end
      OPC_STORE: begin
        enc_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        enc_err = !imm_ok_12;
      end
      OPC_OP, OPC_OP_32: begin
        enc_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        enc_err = 1'b0;
      end
      default: begin
        enc_raw = '0;
        enc_err = 1'b1;
      end
    endcase
  end

  assign enc_word = enc_err ? NOP_INSTR : enc_raw;

  // ---------------------------------------------------------------------------
  // Output FIFO and error counter
  // ---------------------------------------------------------------------------
  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic [LVL_W-1:0]     level_d;
  logic                 out_valid_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 push;
  logic                 pop;
  entry_t               head;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign in_ready = (level_q < LVL_W'(DEPTH)) || (out_valid_q && out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (push && enc_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{err: enc_err, instr: enc_word};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q     <= level_d;
      out_valid_q <= (level_d != '0);
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_instr = head.instr;
  assign out_err   = head.err;
  assign err_cnt   = err_cnt_q;
  assign level     = level_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, error handling, backpressure,
// streaming and reset, plus random traffic against a field-arithmetic model.
module tb_instr_encoder;

  localparam int DEPTH     = 2;
  localparam int ERR_CNT_W = 8;
  localparam int MAXC      = (1 << ERR_CNT_W) - 1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        err_clr;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [$clog2(DEPTH):0] level;

  instr_encoder #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [32:0] q[$];
  int  mcnt = 0;
  int  npop = 0;
  bit  last_accept = 0;

  logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h73};
  logic [31:0] bnd [16] = '{32'hFFFFEFFF, 32'hFFFFF000, 32'hFFFFF001, 32'hFFFFF7FF,
                            32'hFFFFF800, 32'h000007FF, 32'h00000800, 32'h00000FFE,
                            32'h00000FFF, 32'h000FFFFE, 32'h000FFFFF, 32'hFFF00000,
                            32'hFFEFFFFE, 32'h12345000, 32'h0000003F, 32'h00000020};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: assembles the word from field values with arithmetic.
  function automatic void ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm,
                                     output logic [31:0] word, output logic err);
    longint v = longint'($signed(imm));
    longint u = longint'(imm);
    longint w = 0;
    byte fmt;
    err = 0;
    case (op)
      7'h37, 7'h17: fmt = "U";
      7'h6F: fmt = "J";
      7'h67, 7'h03, 7'h73, 7'h13, 7'h1B: fmt = "I";
      7'h63: fmt = "B";
      7'h23: fmt = "S";
      7'h33, 7'h3B: fmt = "R";
      default: begin fmt = "X"; err = 1; end
    endcase
    w = longint'(op);
    if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") w += longint'(rd) * 128;
    if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") begin
      w += longint'(f3) * 4096;
      w += longint'(rs1) * 32768;
    end
    if (fmt == "R" || fmt == "S" || fmt == "B") w += longint'(rs2) * (1 << 20);
    case (fmt)
      "R": w += longint'(f7) * (1 << 25);
      "I": begin
        if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
          if (op == 7'h13) begin
            err = ((u / 64) % 64) != 0;
            w += (u % 64) * (1 << 20);
          end else begin
            err = ((u / 32) % 128) != 0;
            w += (u % 32) * (1 << 20);
          end
          if (f3 == 3'd5 && f7[5]) w += longint'(1) << 30;
        end else begin
          err = v < -2048 || v > 2047;
          w += (u % 4096) * (1 << 20);
        end
      end
      "S": begin
        err = v < -2048 || v > 2047;
        w += ((u / 32) % 128) * (1 << 25) + (u % 32) * 128;
      end
      "B": begin
        err = v < -4096 || v > 4094 || (u % 2) != 0;
        w += ((u >> 12) & 1) * (longint'(1) << 31) + ((u >> 5) & 63) * (1 << 25)
           + ((u >> 1) & 15) * 256 + ((u >> 11) & 1) * 128;
      end
      "J": begin
        err = v < -1048576 || v > 1048574 || (u % 2) != 0;
        w += ((u >> 20) & 1) * (longint'(1) << 31) + ((u >> 1) & 1023) * (1 << 21)
           + ((u >> 11) & 1) * (1 << 20) + ((u >> 12) & 255) * 4096;
      end
      "U": begin
        err = (u % 4096) != 0;
        w += u - (u % 4096);
      end
      default: ;
    endcase
    word = err ? 32'h0000_0013 : 32'(w);
  endfunction

  // One cycle: called at a falling edge with inputs already driven.
  task automatic step();
    logic [31:0] w;
    logic e;
    bit eout, ein, push, pop;
    #1;
    eout = q.size() != 0;
    ein  = (q.size() < DEPTH) || (eout && out_ready);
    check("out_valid", 64'(out_valid), 64'(eout));
    check("in_ready", 64'(in_ready), 64'(ein));
    check("level", 64'(level), 64'(q.size()));
    check("err_cnt", 64'(err_cnt), 64'(mcnt));
    if (eout) begin
      check("out_instr", 64'(out_instr), 64'(q[0][31:0]));
      check("out_err", 64'(out_err), 64'(q[0][32]));
    end
    push = in_valid && ein;
    pop  = eout && out_ready;
    if (pop) begin
      void'(q.pop_front());
      npop++;
    end
    if (push) begin
      ref_encode(in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, w, e);
      q.push_back({e, w});
      if (e && !err_clr && mcnt < MAXC) mcnt++;
    end
    if (err_clr) mcnt = 0;
    last_accept = push;
    @(negedge clk);
  endtask

  task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm);
    in_op = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    req(op, f3, f7, rd, rs1, rs2, imm);
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_accept) break;
    end
    check("send_accept", 64'(last_accept), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] word, input logic err);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_instr"}, 64'(out_instr), 64'(word));
    check({tag, "_err"}, 64'(out_err), 64'(err));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("drain_empty", 64'(out_valid), 64'd0);
  endtask

  task automatic rand_req();
    logic [6:0] op;
    logic [31:0] imm;
    int sel;
    op = ($urandom_range(0, 12) == 0) ? (($urandom_range(0, 1) == 0) ? 7'h7F : 7'h00)
                                      : ops[$urandom_range(0, 11)];
    sel = $urandom_range(0, 4);
    case (sel)
      0: imm = 32'($urandom_range(0, 16)) - 32'd8;
      1: imm = bnd[$urandom_range(0, 15)];
      2: imm = $urandom();
      3: imm = 32'($urandom_range(0, 127));
      default: imm = $urandom() & 32'hFFFF_F000;
    endcase
    req(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
  endtask

  task automatic rand_legal_req();
    req(7'h33, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom());
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_op = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed encodings, one word visible the cycle after accept.
    out_ready = 1'b1;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_head("addi", 32'h0050_0093, 1'b0); step();
    send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_head("sw", 32'h0020_A423, 1'b0); step();
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    expect_head("beq", 32'hFE00_0EE3, 1'b0); step();
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    expect_head("jal", 32'h0010_00EF, 1'b0); step();
    send(7'h13, 3'd5, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3);
    expect_head("srai", 32'h4030_D093, 1'b0); step();

    // Rejected requests and the error counter.
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    expect_head("err_addi", 32'h0000_0013, 1'b1); step();
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    expect_head("err_beq", 32'h0000_0013, 1'b1); step();
    send(7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h123);
    expect_head("err_lui", 32'h0000_0013, 1'b1);
    check("err_cnt3", 64'(err_cnt), 64'd3);
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr", 64'(err_cnt), 64'd0);

    begin
      int acc = 0;
      req(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
      for (int i = 0; i < 600 && acc < MAXC; i++) begin
        step();
        if (last_accept) acc++;
      end
      check("sat_reach", 64'(err_cnt), 64'(MAXC));
      step();
      check("sat_hold", 64'(err_cnt), 64'(MAXC));
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("clr_over_inc", 64'(err_cnt), 64'd0);
    end
    drain();

    // Backpressure: two buffered, third held until space frees.
    out_ready = 1'b0;
    send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    check("bp_level", 64'(level), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    req(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    repeat (3) step();
    check("bp_held", 64'(last_accept), 64'd0);
    out_ready = 1'b1;
    expect_head("bp_a", 32'h0020_A423, 1'b0); step();
    check("bp_c_acc", 64'(last_accept), 64'd1);
    in_valid = 1'b0;
    expect_head("bp_b", 32'h0010_00EF, 1'b0); step();
    expect_head("bp_c", 32'hFE00_0EE3, 1'b0); step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Full FIFO streaming: one push and one pop per cycle.
    out_ready = 1'b0;
    rand_legal_req(); step(); rand_legal_req(); step();
    out_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 16; i++) begin
      rand_legal_req();
      check("stream_level", 64'(level), 64'd2);
      step();
      check("stream_acc", 64'(last_accept), 64'd1);
    end
    drain();
    check("stream_pops", 64'(npop), 64'd18);

    // Random traffic with held requests under backpressure.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_accept) begin
        if ($urandom_range(0, 3) != 0) rand_req();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      step();
    end
    err_clr = 1'b0;
    drain();

    // Asynchronous reset with data buffered and a nonzero counter.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    drain();
    out_ready = 1'b0;
    send(7'h33, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 32'd0);
    send(7'h33, 3'd0, 7'd0, 5'd6, 5'd7, 5'd8, 32'd0);
    check("pre_rst_level", 64'(level), 64'd2);
    check("pre_rst_cnt", 64'(err_cnt), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_err_cnt", 64'(err_cnt), 64'd0);
    check("arst_out_instr", 64'(out_instr), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_head("post_rst", 32'h0050_0093, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
